// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation engine.
package life_pkg;

  // Engine sequencing states. A generation walks:
  // LD_LAST_RD/WT, LD_FIRST_RD/WT, (ROW_RD, ROW_WT, ROW_WR) x (HEIGHT-1),
  // LAST_WR, GEN_END.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_LAST_RD,
    ST_LD_LAST_WT,
    ST_LD_FIRST_RD,
    ST_LD_FIRST_WT,
    ST_ROW_RD,
    ST_ROW_WT,
    ST_ROW_WR,
    ST_LAST_WR,
    ST_GEN_END
  } state_t;

  // Standard B3/S23 rule masks (bit n = neighbour count n).
  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

  // Neighbour count spans 0..8, so it needs four bits to avoid aliasing 8 to 0.
  localparam int CNT_W = 4;

  // Zero-extend a single cell bit to the neighbour-count width.
  function automatic logic [CNT_W-1:0] bit_to_cnt(input logic b);
    return {{(CNT_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row from a three-row window.
// Column edges either wrap (torus) or read as dead cells.
module life_row_next
  import life_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_nxt,
  input  logic [8:0]       i_birth_mask,
  input  logic [8:0]       i_survive_mask,
  output logic [WIDTH-1:0] o_next
);

  // Each row padded with one halo cell on both sides; halo index k+1 is column k.
  logic [WIDTH+1:0] w_p;
  logic [WIDTH+1:0] w_c;
  logic [WIDTH+1:0] w_n;
  logic [CNT_W-1:0] w_cnt [WIDTH];

  assign w_p = {(WRAP != 0) ? i_prev[0] : 1'b0, i_prev, (WRAP != 0) ? i_prev[WIDTH-1] : 1'b0};
  assign w_c = {(WRAP != 0) ? i_cur[0]  : 1'b0, i_cur,  (WRAP != 0) ? i_cur[WIDTH-1]  : 1'b0};
  assign w_n = {(WRAP != 0) ? i_nxt[0]  : 1'b0, i_nxt,  (WRAP != 0) ? i_nxt[WIDTH-1]  : 1'b0};

  // Count the eight neighbours per column and apply the birth/survive rule.
  always_comb begin
    o_next = '0;
    w_cnt  = '{default: '0};
    for (int c = 0; c < WIDTH; c++) begin
      w_cnt[c] = bit_to_cnt(w_p[c]) + bit_to_cnt(w_p[c+1]) + bit_to_cnt(w_p[c+2])
               + bit_to_cnt(w_c[c])                        + bit_to_cnt(w_c[c+2])
               + bit_to_cnt(w_n[c]) + bit_to_cnt(w_n[c+1]) + bit_to_cnt(w_n[c+2]);
      o_next[c] = i_cur[c] ? i_survive_mask[w_cnt[c]] : i_birth_mask[w_cnt[c]];
    end
  end

endmodule

// File: rtl/life_gen_engine.sv
// In-place Game-of-Life generation sequencer over a single-port row memory.
// Holds a sliding prev/cur/nxt window plus a copy of the original row 0,
// which is needed for the last row after row 0 has been overwritten.
// Handshake: start is accepted only while busy=0; busy stays high until the
// run ends, when done pulses together with the final gen_done and busy drops.
module life_gen_engine
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 8,
  parameter int WRAP   = 1,
  parameter int AW     = $clog2(HEIGHT)
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [GEN_W-1:0] gens,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic             busy,
  output logic             gen_done,
  output logic             done,
  output logic [GEN_W-1:0] gen_cnt,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd_en,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wr_data,
  output state_t           o_dbg_state
);

  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);
  localparam logic [AW-1:0] PEN_ROW  = AW'(HEIGHT - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_row;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] r_first;
  logic [8:0]       r_birth;
  logic [8:0]       r_survive;
  logic [GEN_W-1:0] r_gens;
  logic [GEN_W-1:0] r_gens_left;
  logic             r_stop_seen;
  logic             r_busy;
  logic             r_gen_done;
  logic             r_done;
  logic [GEN_W-1:0] r_gen_cnt;

  logic [WIDTH-1:0] w_below;
  logic [WIDTH-1:0] w_row_next;
  logic [AW-1:0]    w_addr;
  logic             w_rd_en;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_more;

  // The last row's lower neighbour is the saved original row 0 (or dead rows).
  assign w_below = (r_state == ST_LAST_WR) ? ((WRAP != 0) ? r_first : '0) : r_nxt;

  life_row_next #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_row_next (
    .i_prev         (r_prev),
    .i_cur          (r_cur),
    .i_nxt          (w_below),
    .i_birth_mask   (r_birth),
    .i_survive_mask (r_survive),
    .o_next         (w_row_next)
  );

  // State register.
  always_ff @(posedge ph1) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and memory command outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = '0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    w_more      = 1'b0;
    case (r_state)
      ST_IDLE:        if (start) w_state_nxt = ST_LD_LAST_RD;
      ST_LD_LAST_RD: begin
        w_addr      = LAST_ROW;
        w_rd_en     = 1'b1;
        w_state_nxt = ST_LD_LAST_WT;
      end
      ST_LD_LAST_WT:  w_state_nxt = ST_LD_FIRST_RD;
      ST_LD_FIRST_RD: begin
        w_addr      = '0;
        w_rd_en     = 1'b1;
        w_state_nxt = ST_LD_FIRST_WT;
      end
      ST_LD_FIRST_WT: w_state_nxt = ST_ROW_RD;
      ST_ROW_RD: begin
        w_addr      = r_row + AW'(1);
        w_rd_en     = 1'b1;
        w_state_nxt = ST_ROW_WT;
      end
      ST_ROW_WT:      w_state_nxt = ST_ROW_WR;
      ST_ROW_WR: begin
        w_addr      = r_row;
        w_wr_en     = 1'b1;
        w_wr_data   = w_row_next;
        w_state_nxt = (r_row == PEN_ROW) ? ST_LAST_WR : ST_ROW_RD;
      end
      ST_LAST_WR: begin
        w_addr      = LAST_ROW;
        w_wr_en     = 1'b1;
        w_wr_data   = w_row_next;
        w_state_nxt = ST_GEN_END;
      end
      ST_GEN_END: begin
        // Counted run: continue unless this was the last one.
        // Free run: continue unless stop has been seen (including this cycle).
        if (r_gens != '0) w_more = (r_gens_left != GEN_W'(1));
        else              w_more = !(r_stop_seen || stop);
        w_state_nxt = w_more ? ST_LD_LAST_RD : ST_IDLE;
      end
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  // Window registers, run configuration, counters and status pulses.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      r_row       <= '0;
      r_prev      <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_first     <= '0;
      r_birth     <= '0;
      r_survive   <= '0;
      r_gens      <= '0;
      r_gens_left <= '0;
      r_stop_seen <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
      r_done      <= 1'b0;
      r_gen_cnt   <= '0;
    end else begin
      r_gen_done <= 1'b0;
      r_done     <= 1'b0;
      if (r_busy && stop) r_stop_seen <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_gens      <= gens;
            r_gens_left <= gens;
            r_birth     <= birth_mask;
            r_survive   <= survive_mask;
            r_stop_seen <= 1'b0;
            r_busy      <= 1'b1;
            r_row       <= '0;
          end
        end
        ST_LD_LAST_WT:  r_prev <= (WRAP != 0) ? mem_rd_data : '0;
        ST_LD_FIRST_WT: begin
          r_cur   <= mem_rd_data;
          r_first <= mem_rd_data;
        end
        ST_ROW_WT:      r_nxt <= mem_rd_data;
        ST_ROW_WR: begin
          r_prev <= r_cur;
          r_cur  <= r_nxt;
          r_row  <= r_row + AW'(1);
        end
        ST_GEN_END: begin
          r_gen_done <= 1'b1;
          r_gen_cnt  <= r_gen_cnt + GEN_W'(1);
          r_row      <= '0;
          if (r_gens != '0) r_gens_left <= r_gens_left - GEN_W'(1);
          if (!w_more) begin
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_stop_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign gen_done    = r_gen_done;
  assign done        = r_done;
  assign gen_cnt     = r_gen_cnt;
  assign mem_addr    = w_addr;
  assign mem_rd_en   = w_rd_en;
  assign mem_wr_en   = w_wr_en;
  assign mem_wr_data = w_wr_data;
  assign o_dbg_state = r_state;

endmodule
